// File: rtl/mips_mem_master_pkg.sv
// Shared encodings for the MIPS byte-RAM master: mem_ctrl values and FSM states.
package mips_mem_master_pkg;

   localparam logic [1:0] MEM_IDLE = 2'b00;
   localparam logic [1:0] MEM_WR   = 2'b01;
   localparam logic [1:0] MEM_RD   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_W_SEND = 3'd1,
      ST_W_REL  = 3'd2,
      ST_R_ARM  = 3'd3,
      ST_R_WAIT = 3'd4,
      ST_R_REL  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // States that wait on a RAM handshake edge and are therefore guarded by the timeout.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_W_SEND) || (s == ST_W_REL) || (s == ST_R_WAIT) || (s == ST_R_REL);
   endfunction

endpackage

// File: rtl/mips_mem_master_if.sv
// Core request/response and byte-RAM handshake signals of the MIPS memory master.
interface mips_mem_master_if #(
   parameter int AW = 16
) ();
   import mips_mem_master_pkg::*;

   // Core side: a request transfers on a rising clk edge where req_valid=1 and req_ready=1;
   // req_ready is high only while idle, and rsp_valid is a one-cycle completion pulse with
   // no back-pressure from the core.
   logic          req_valid;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic          req_ready;
   logic          rsp_valid;
   logic [15:0]   rsp_rdata;
   logic          rsp_err;

   // RAM side byte handshake.
   logic [AW-1:0] data_addr;
   logic [7:0]    data_store;
   logic [7:0]    data_read;
   logic [1:0]    mem_ctrl;
   logic          cpu_send;
   logic          ram_receive;
   logic          cpu_ready;
   logic          ram_send;
   logic          cpu_receive;

   state_t        fsm_state;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, data_read, ram_receive, ram_send,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, data_addr, data_store, mem_ctrl,
             cpu_send, cpu_ready, cpu_receive, fsm_state
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, data_read, ram_receive, ram_send,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, data_addr, data_store, mem_ctrl,
             cpu_send, cpu_ready, cpu_receive, fsm_state
   );

endinterface

// File: rtl/mips_mem_master_timeout.sv
// Per-state cycle counter: cleared on every state change, flags expiry after TIMEOUT cycles.
module mips_mem_master_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   // The counter only needs to reach TIMEOUT-1: that is the last cycle of the allowed window.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   assign expired = run && (cnt_q == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (run && (cnt_q != LIMIT)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mips_mem_master.sv
// CPU-side initiator for the MIPS byte RAM: splits each 16-bit load/store into two
// byte handshakes (high byte first) and returns one completion pulse to the core.
module mips_mem_master
   import mips_mem_master_pkg::*;
#(
   parameter int AW      = 16,
   parameter int TIMEOUT = 255
) (
   input logic             clk,
   input logic             rst_n,
   mips_mem_master_if.master bus
);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    wdata_lo_q, wdata_lo_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          b_q, b_d;

   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [15:0]   rsp_rdata_q, rsp_rdata_d;
   logic [7:0]    data_store_q, data_store_d;
   logic [1:0]    mem_ctrl_q, mem_ctrl_d;
   logic          cpu_send_q, cpu_send_d;
   logic          cpu_ready_q, cpu_ready_d;
   logic          cpu_receive_q, cpu_receive_d;

   logic          expired;
   logic          abort;

   mips_mem_master_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_d != state_q),
      .run     (is_wait_state(state_q)),
      .expired (expired)
   );

   // Every output is computed one cycle ahead and registered on entry to the state it belongs to.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_lo_d    = wdata_lo_q;
      rdata_d       = rdata_q;
      b_d           = b_q;
      data_store_d  = data_store_q;
      mem_ctrl_d    = mem_ctrl_q;
      cpu_send_d    = cpu_send_q;
      cpu_receive_d = cpu_receive_q;
      cpu_ready_d   = 1'b0;
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_rdata_d   = '0;
      abort         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               addr_d     = bus.req_addr;
               addr_d[0]  = 1'b0;
               wdata_lo_d = bus.req_wdata[7:0];
               rdata_d    = '0;
               b_d        = 1'b0;
               if (bus.req_we) begin
                  state_d      = ST_W_SEND;
                  mem_ctrl_d   = MEM_WR;
                  data_store_d = bus.req_wdata[15:8];
                  cpu_send_d   = 1'b1;
               end else begin
                  state_d     = ST_R_ARM;
                  mem_ctrl_d  = MEM_RD;
                  cpu_ready_d = 1'b1;
               end
            end
         end

         ST_W_SEND: begin
            if (bus.ram_receive) begin
               cpu_send_d = 1'b0;
               state_d    = ST_W_REL;
            end else if (expired) begin
               abort = 1'b1;
            end
         end

         ST_W_REL: begin
            if (!bus.ram_receive) begin
               if (!b_q) begin
                  b_d          = 1'b1;
                  addr_d       = {addr_q[AW-1:1], 1'b1};
                  data_store_d = wdata_lo_q;
                  cpu_send_d   = 1'b1;
                  state_d      = ST_W_SEND;
               end else begin
                  mem_ctrl_d  = MEM_IDLE;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end
            end else if (expired) begin
               abort = 1'b1;
            end
         end

         ST_R_ARM: begin
            state_d = ST_R_WAIT;
         end

         ST_R_WAIT: begin
            if (bus.ram_send) begin
               if (b_q) rdata_d[7:0]  = bus.data_read;
               else     rdata_d[15:8] = bus.data_read;
               cpu_receive_d = 1'b1;
               state_d       = ST_R_REL;
            end else if (expired) begin
               abort = 1'b1;
            end
         end

         ST_R_REL: begin
            if (!bus.ram_send) begin
               cpu_receive_d = 1'b0;
               if (!b_q) begin
                  b_d         = 1'b1;
                  addr_d      = {addr_q[AW-1:1], 1'b1};
                  cpu_ready_d = 1'b1;
                  state_d     = ST_R_ARM;
               end else begin
                  mem_ctrl_d  = MEM_IDLE;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = rdata_q;
                  state_d     = ST_DONE;
               end
            end else if (expired) begin
               abort = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A stalled RAM handshake is abandoned and reported back to the core as an error.
      if (abort) begin
         state_d       = ST_IDLE;
         b_d           = 1'b0;
         cpu_send_d    = 1'b0;
         cpu_receive_d = 1'b0;
         mem_ctrl_d    = MEM_IDLE;
         rsp_valid_d   = 1'b1;
         rsp_err_d     = 1'b1;
         rsp_rdata_d   = '0;
      end

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_lo_q    <= '0;
         rdata_q       <= '0;
         b_q           <= 1'b0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_rdata_q   <= '0;
         data_store_q  <= '0;
         mem_ctrl_q    <= MEM_IDLE;
         cpu_send_q    <= 1'b0;
         cpu_ready_q   <= 1'b0;
         cpu_receive_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_lo_q    <= wdata_lo_d;
         rdata_q       <= rdata_d;
         b_q           <= b_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_err_q     <= rsp_err_d;
         rsp_rdata_q   <= rsp_rdata_d;
         data_store_q  <= data_store_d;
         mem_ctrl_q    <= mem_ctrl_d;
         cpu_send_q    <= cpu_send_d;
         cpu_ready_q   <= cpu_ready_d;
         cpu_receive_q <= cpu_receive_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.data_addr   = addr_q;
   assign bus.data_store  = data_store_q;
   assign bus.mem_ctrl    = mem_ctrl_q;
   assign bus.cpu_send    = cpu_send_q;
   assign bus.cpu_ready   = cpu_ready_q;
   assign bus.cpu_receive = cpu_receive_q;
   assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_mips_mem_master.sv
// Bench for mips_mem_master: byte-RAM responder model, response scoreboard, vector table
// and hand-written sequences for timeout, address wrap and asynchronous reset.
module tb_mips_mem_master;
   import mips_mem_master_pkg::*;

   localparam int AW = 16;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mips_mem_master_if #(.AW(AW)) bus ();
   mips_mem_master_if #(.AW(AW)) bus2 ();

   mips_mem_master #(.AW(AW), .TIMEOUT(40)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mips_mem_master #(.AW(AW), .TIMEOUT(8)) dut_to (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int          total = 0;
   int          bad = 0;
   logic [16:0] exp_q[$];
   logic [7:0]  ram [0:65535];
   logic [7:0]  ref_mem [int];
   logic [15:0] rd_log[$];
   int          w_delay = 0;
   int          rd_delay1 = 0;
   int          ready_pulses = 0;
   int          ctrl_viol = 0;
   int          busy_ready_viol = 0;
   int          ready_long_viol = 0;
   logic        in_flight = 1'b0;
   logic        prev_cpu_ready = 1'b0;

   logic [47:0] main_outs;
   assign main_outs = {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.data_addr,
                       bus.data_store, bus.mem_ctrl, bus.cpu_send, bus.cpu_ready, bus.cpu_receive};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Byte-RAM responder for the main DUT.
   initial begin
      int          w_cnt;
      int          r_cnt;
      logic        r_pend;
      logic [15:0] r_addr;
      w_cnt = 0;
      r_cnt = 0;
      r_pend = 1'b0;
      r_addr = '0;
      bus.ram_receive = 1'b0;
      bus.ram_send = 1'b0;
      bus.data_read = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            bus.ram_receive = 1'b0;
            bus.ram_send = 1'b0;
            w_cnt = 0;
            r_pend = 1'b0;
         end else begin
            if (bus.cpu_send && bus.mem_ctrl == MEM_WR && !bus.ram_receive) begin
               if (w_cnt >= w_delay) begin
                  ram[bus.data_addr] = bus.data_store;
                  bus.ram_receive = 1'b1;
                  w_cnt = 0;
               end else begin
                  w_cnt++;
               end
            end else if (!bus.cpu_send && bus.ram_receive) begin
               bus.ram_receive = 1'b0;
            end
            if (bus.cpu_ready && bus.mem_ctrl == MEM_RD) begin
               r_pend = 1'b1;
               r_addr = bus.data_addr;
               r_cnt = 0;
               rd_log.push_back(bus.data_addr);
            end else if (r_pend) begin
               if (r_cnt >= (r_addr[0] ? rd_delay1 : 0)) begin
                  bus.data_read = ram[r_addr];
                  bus.ram_send = 1'b1;
                  r_pend = 1'b0;
               end else begin
                  r_cnt++;
               end
            end
            if (bus.cpu_receive && bus.ram_send) bus.ram_send = 1'b0;
         end
      end
   end

   // Monitor and scoreboard, sampled on the falling edge.
   initial begin
      logic [16:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.mem_ctrl == 2'b11) ctrl_viol++;
            if (bus2.mem_ctrl == 2'b11) ctrl_viol++;
            if (bus.cpu_ready) begin
               ready_pulses++;
               if (prev_cpu_ready) ready_long_viol++;
            end
            prev_cpu_ready = bus.cpu_ready;
            if (in_flight && bus.req_ready) busy_ready_viol++;
            if (bus.rsp_valid) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rsp_unexpected: got err=%0b rdata=0x%0h expected no response",
                           bus.rsp_err, bus.rsp_rdata);
               end else begin
                  exp = exp_q.pop_front();
                  check("rsp", {bus.rsp_err, bus.rsp_rdata}, 64'(exp));
               end
               in_flight = 1'b0;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata);
      int guard = 0;
      @(posedge clk);
      #1;
      while (!bus.req_ready && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!bus.req_ready) begin
         total++;
         bad++;
         $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 200 cycles");
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_addr = addr;
      bus.req_wdata = wdata;
      exp_q.push_back({1'b0, exp_rdata});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      in_flight = 1'b1;
   endtask

   task automatic wait_rsp(input string name);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 400) begin
         @(posedge clk);
         guard++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s: got %0d responses pending expected 0 after 400 cycles", name, exp_q.size());
         exp_q.delete();
         in_flight = 1'b0;
      end
   endtask

   task automatic ref_store(input logic [15:0] addr, input logic [15:0] data);
      ref_mem[int'({addr[15:1], 1'b0})] = data[15:8];
      ref_mem[int'({addr[15:1], 1'b1})] = data[7:0];
   endtask

   task automatic timeout_txn(input logic we, input string name);
      int   guard = 0;
      int   send_cyc = 0;
      int   ready_cyc = 0;
      logic got = 1'b0;
      @(posedge clk);
      #1;
      while (!bus2.req_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      bus2.req_valid = 1'b1;
      bus2.req_we = we;
      bus2.req_addr = 16'h0040;
      bus2.req_wdata = 16'h1111;
      @(posedge clk);
      #1;
      bus2.req_valid = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (bus2.rsp_valid) begin
            got = 1'b1;
            check({name, "_err"}, bus2.rsp_err, 1);
            check({name, "_rdata"}, bus2.rsp_rdata, 0);
            check({name, "_cpu_send"}, bus2.cpu_send, 0);
            check({name, "_mem_ctrl"}, bus2.mem_ctrl, 0);
         end else begin
            if (bus2.cpu_send) send_cyc++;
            if (bus2.cpu_ready) ready_cyc++;
         end
      end
      check({name, "_got_rsp"}, got, 1);
      if (we) check({name, "_send_cycles"}, send_cyc, 8);
      else    check({name, "_ready_pulses"}, ready_cyc, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[9];
      logic [15:0] a;
      logic [15:0] d;
      int          p0;
      int          t0;

      vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF};
      vecs[3] = '{1'b1, 16'h0101, 16'hA55A, 16'h0000};
      vecs[4] = '{1'b0, 16'h0100, 16'h0000, 16'hA55A};
      vecs[5] = '{1'b1, 16'h0020, 16'h00FF, 16'h0000};
      vecs[6] = '{1'b0, 16'h0020, 16'h0000, 16'h00FF};
      vecs[7] = '{1'b1, 16'h0030, 16'h8001, 16'h0000};
      vecs[8] = '{1'b0, 16'h0031, 16'h0000, 16'h8001};

      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      bus2.req_valid = 1'b0;
      bus2.req_we = 1'b0;
      bus2.req_addr = '0;
      bus2.req_wdata = '0;
      bus2.ram_receive = 1'b0;
      bus2.ram_send = 1'b0;
      bus2.data_read = '0;
      ram[16'hFFFE] = 8'h12;
      ram[16'hFFFF] = 8'h34;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", main_outs, 0);
      check("reset_state", bus.fsm_state, ST_IDLE);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", bus.req_ready, 1);

      // Responder-less DUT: RAM never answers.
      timeout_txn(1'b1, "wr_timeout");
      timeout_txn(1'b0, "rd_timeout");

      for (int i = 0; i < 9; i++) begin
         w_delay = i % 3;
         if (vecs[i].we) ref_store(vecs[i].addr, vecs[i].wdata);
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
         wait_rsp("vec_rsp");
      end
      w_delay = 0;
      check("ram_0010", ram[16'h0010], 8'hBE);
      check("ram_0011", ram[16'h0011], 8'hEF);

      p0 = ready_pulses;
      do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
      wait_rsp("load_pulses_rsp");
      check("load_cpu_ready_pulses", ready_pulses - p0, 2);

      rd_delay1 = 20;
      t0 = 0;
      do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
      while (exp_q.size() != 0 && t0 < 400) begin
         @(posedge clk);
         t0++;
      end
      check("slow_byte1_latency_ge20", (t0 >= 20), 1);
      wait_rsp("slow_byte1_rsp");
      rd_delay1 = 0;

      rd_log.delete();
      do_req(1'b0, 16'hFFFE, 16'h0000, 16'h1234);
      wait_rsp("wrap_rsp");
      check("wrap_addr_count", rd_log.size(), 2);
      if (rd_log.size() == 2) begin
         check("wrap_addr0", rd_log[0], 16'hFFFE);
         check("wrap_addr1", rd_log[1], 16'hFFFF);
      end

      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom_range(32'h0300, 32'h03FF));
         d = 16'($urandom);
         w_delay = $urandom_range(0, 3);
         rd_delay1 = $urandom_range(0, 4);
         ref_store(a, d);
         do_req(1'b1, a, d, 16'h0000);
         wait_rsp("rand_store_rsp");
         do_req(1'b0, a, 16'h0000,
                {ref_mem[int'({a[15:1], 1'b0})], ref_mem[int'({a[15:1], 1'b1})]});
         wait_rsp("rand_load_rsp");
      end
      rd_delay1 = 0;

      // Reset while a store waits in W_SEND.
      w_delay = 4;
      do_req(1'b1, 16'h0200, 16'hCAFE, 16'h0000);
      check("cpu_send_before_reset", bus.cpu_send, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", main_outs, 0);
      check("async_reset_state", bus.fsm_state, ST_IDLE);
      exp_q.delete();
      in_flight = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      w_delay = 0;
      do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
      wait_rsp("post_reset_load_rsp");

      repeat (3) @(posedge clk);
      check("mem_ctrl_never_11", ctrl_viol, 0);
      check("req_ready_low_while_busy", busy_ready_viol, 0);
      check("cpu_ready_single_cycle", ready_long_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
